// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte sources.
// A granted source keeps the UART until its last byte or an idle timeout.
module uart_tx_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic [N-1:0]   Req,
   input  logic [8*N-1:0] Data,
   input  logic [N-1:0]   Last,
   output logic [N-1:0]   Ack,
   output logic [N-1:0]   Grant,
   output logic           Busy,
   output logic           TimedOut,
   input  logic           TxEmpty,
   output logic           XMitGo,
   output logic [7:0]     TxData
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state;
   logic [PW-1:0]  ptr;
   logic [PW-1:0]  owner;
   logic [PW-1:0]  winner;
   logic [PW-1:0]  cand;
   logic           found;
   logic           last_latched;
   logic [CW-1:0]  cnt;
   logic [7:0]     bytes [N];
   int unsigned    idx;

   for (genvar i = 0; i < N; i++) begin : g_bytes
      assign bytes[i] = Data[8*i +: 8];
   end

   // Scan requests starting just after the most recent owner, wrapping around.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      cand   = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx  = (32'(ptr) + k) % N;
         cand = PW'(idx);
         if (!found && Req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         ptr          <= PW'(N - 1);
         owner        <= '0;
         last_latched <= 1'b0;
         cnt          <= '0;
         Ack          <= '0;
         Grant        <= '0;
         Busy         <= 1'b0;
         TimedOut     <= 1'b0;
         XMitGo       <= 1'b0;
         TxData       <= 8'h00;
      end else begin
         Ack      <= '0;
         TimedOut <= 1'b0;
         case (state)
            IDLE: begin
               if (TxEmpty && found) begin
                  owner        <= winner;
                  Grant        <= N'(1) << winner;
                  TxData       <= bytes[winner];
                  last_latched <= Last[winner];
                  XMitGo       <= 1'b1;
                  Busy         <= 1'b1;
                  state        <= SEND;
               end
            end
            SEND: begin
               // The UART drops TxEmpty when it takes the byte.
               if (!TxEmpty) begin
                  XMitGo     <= 1'b0;
                  Ack[owner] <= 1'b1;
                  if (last_latched) begin
                     ptr   <= owner;
                     Grant <= '0;
                     Busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     cnt   <= '0;
                     state <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (TxEmpty && Req[owner]) begin
                  TxData       <= bytes[owner];
                  last_latched <= Last[owner];
                  XMitGo       <= 1'b1;
                  state        <= SEND;
               end else if (TIMEOUT != 0 && TxEmpty) begin
                  if (cnt == CW'(TIMEOUT - 1)) begin
                     TimedOut <= 1'b1;
                     ptr      <= owner;
                     Grant    <= '0;
                     Busy     <= 1'b0;
                     cnt      <= '0;
                     state    <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: begin
               state  <= IDLE;
               XMitGo <= 1'b0;
               Grant  <= '0;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single source, round-robin, lock,
// timeout and mid-send reset, with a hand-driven UART TxEmpty handshake.
module tb_uart_tx_arbiter;

   logic        Clock;
   logic        Reset;
   logic [3:0]  Req;
   logic [31:0] Data;
   logic [3:0]  Last;
   logic [3:0]  Ack;
   logic [3:0]  Grant;
   logic        Busy;
   logic        TimedOut;
   logic        TxEmpty;
   logic        XMitGo;
   logic [7:0]  TxData;

   int total = 0;
   int bad   = 0;

   uart_tx_arbiter #(.N(4), .TIMEOUT(16)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Req      (Req),
      .Data     (Data),
      .Last     (Last),
      .Ack      (Ack),
      .Grant    (Grant),
      .Busy     (Busy),
      .TimedOut (TimedOut),
      .TxEmpty  (TxEmpty),
      .XMitGo   (XMitGo),
      .TxData   (TxData)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic raise(input int s, input logic [7:0] b, input logic l);
      Req[s]          = 1'b1;
      Data[8*s +: 8]  = b;
      Last[s]         = l;
   endtask

   // Wait for the strobe, check the offered byte, then play the UART taking it.
   task automatic serve(input int s, input logic [7:0] b, input logic l);
      int n;
      logic [3:0] oh;
      oh = 4'b0001 << s;
      n  = 0;
      while (XMitGo !== 1'b1 && n < 40) begin
         @(negedge Clock);
         n++;
      end
      chk("xmitgo", 8'(XMitGo), 8'h01);
      chk("grant_send", 8'(Grant), 8'(oh));
      chk("txdata", TxData, b);
      chk("busy_send", 8'(Busy), 8'h01);
      TxEmpty = 1'b0;
      @(negedge Clock);
      chk("ack", 8'(Ack), 8'(oh));
      chk("xmitgo_low", 8'(XMitGo), 8'h00);
      chk("grant_after", 8'(Grant), l ? 8'h00 : 8'(oh));
      chk("busy_after", 8'(Busy), l ? 8'h00 : 8'h01);
      Req[s] = 1'b0;
      @(negedge Clock);
      chk("ack_single", 8'(Ack), 8'h00);
      repeat (8) @(negedge Clock);
      TxEmpty = 1'b1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
   endtask

   initial begin
      Reset   = 1'b1;
      Req     = '0;
      Data    = '0;
      Last    = '0;
      TxEmpty = 1'b1;
      @(negedge Clock);
      do_reset();
      chk("rst_xmitgo", 8'(XMitGo), 8'h00);
      chk("rst_txdata", TxData, 8'h00);
      chk("rst_ack", 8'(Ack), 8'h00);
      chk("rst_grant", 8'(Grant), 8'h00);
      chk("rst_busy", 8'(Busy), 8'h00);
      chk("rst_timedout", 8'(TimedOut), 8'h00);

      // Single source 2, three-byte message
      raise(2, 8'h48, 1'b0);
      serve(2, 8'h48, 1'b0);
      raise(2, 8'h49, 1'b0);
      serve(2, 8'h49, 1'b0);
      raise(2, 8'h0A, 1'b1);
      serve(2, 8'h0A, 1'b1);

      // Round-robin from a fresh pointer, twice
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < 4; s++) raise(s, 8'(8'hA0 + s), 1'b1);
         for (int s = 0; s < 4; s++) serve(s, 8'(8'hA0 + s), 1'b1);
      end
      raise(1, 8'hB1, 1'b1);
      serve(1, 8'hB1, 1'b1);
      raise(1, 8'hC1, 1'b1);
      raise(3, 8'hC3, 1'b1);
      serve(3, 8'hC3, 1'b1);
      serve(1, 8'hC1, 1'b1);

      // Lock: source 0 holds the UART for four bytes while source 1 waits
      raise(1, 8'hE1, 1'b1);
      raise(0, 8'hD0, 1'b0);
      serve(0, 8'hD0, 1'b0);
      raise(0, 8'hD1, 1'b0);
      serve(0, 8'hD1, 1'b0);
      raise(0, 8'hD2, 1'b0);
      serve(0, 8'hD2, 1'b0);
      raise(0, 8'hD3, 1'b1);
      serve(0, 8'hD3, 1'b1);
      serve(1, 8'hE1, 1'b1);

      // Timeout: owner 0 goes quiet after a non-last byte
      raise(0, 8'hF0, 1'b0);
      serve(0, 8'hF0, 1'b0);
      raise(3, 8'hF3, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         @(negedge Clock);
         chk("timedout_cnt", 8'(TimedOut), (i == 16) ? 8'h01 : 8'h00);
      end
      chk("to_grant", 8'(Grant), 8'h00);
      chk("to_busy", 8'(Busy), 8'h00);
      @(negedge Clock);
      chk("to_pulse", 8'(TimedOut), 8'h00);
      serve(3, 8'hF3, 1'b1);

      // Move the pointer to 0 so the reset below is observable in arbitration
      raise(0, 8'h10, 1'b1);
      serve(0, 8'h10, 1'b1);

      // Reset while XMitGo is high
      raise(1, 8'h21, 1'b1);
      @(negedge Clock);
      chk("pre_rst_xmitgo", 8'(XMitGo), 8'h01);
      chk("pre_rst_grant", 8'(Grant), 8'h02);
      raise(0, 8'h20, 1'b1);
      Reset = 1'b1;
      @(negedge Clock);
      chk("mid_xmitgo", 8'(XMitGo), 8'h00);
      chk("mid_grant", 8'(Grant), 8'h00);
      chk("mid_ack", 8'(Ack), 8'h00);
      chk("mid_busy", 8'(Busy), 8'h00);
      chk("mid_txdata", TxData, 8'h00);
      Reset = 1'b0;
      serve(0, 8'h20, 1'b1);
      serve(1, 8'h21, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
